// File: rtl/ram_block_copy_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_block_copy_if
// Description : Control handshake and single-port RAM bus of the block copier.
// Revision    : 1.0
// ============================================================================
interface ram_block_copy_if #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 2
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] src;
    logic [ADDRESS_WIDTH-1:0] dst;
    logic [ADDRESS_WIDTH:0]   len;
    logic                     busy;
    logic                     done;
    logic [ADDRESS_WIDTH-1:0] ad;
    logic                     st;
    logic [BUS_WIDTH-1:0]     X;
    logic [BUS_WIDTH-1:0]     O;

    // master is the copier: it owns the RAM address/store/write-data side
    modport master (
        input  start, src, dst, len, O,
        output busy, done, ad, st, X
    );

    modport slave (
        output start, src, dst, len, O,
        input  busy, done, ad, st, X
    );
endinterface
`default_nettype wire

// File: rtl/ram_block_copy.sv
`default_nettype none
// ============================================================================
// Module      : ram_block_copy
// Description : Copies len words inside a single-port RAM, one READ and one
//               WRITE cycle per word, ascending addresses, forward overlap.
// Revision    : 1.0
// ============================================================================
module ram_block_copy #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ram_block_copy_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] C_PTR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   C_CNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   C_CNT_ZERO = '0;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDRESS_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
    logic                     st_q, st_d;
    logic [BUS_WIDTH-1:0]     data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] w_src_next;
    logic [ADDRESS_WIDTH-1:0] w_dst_next;

    assign w_src_next = src_ptr_q + C_PTR_ONE;
    assign w_dst_next = dst_ptr_q + C_PTR_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            ad_q      <= '0;
            st_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            ad_q      <= ad_d;
            st_q      <= st_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        ad_d      = ad_q;
        st_d      = 1'b0;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len != C_CNT_ZERO) begin
                        src_ptr_d = bus.src;
                        dst_ptr_d = bus.dst;
                        cnt_d     = bus.len;
                        ad_d      = bus.src;
                        state_d   = S_READ;
                    end else begin
                        state_d   = S_DONE;
                    end
                end
            end
            S_READ: begin
                // The RAM is asynchronous-read, so O already reflects ad here
                data_d  = bus.O;
                ad_d    = dst_ptr_q;
                st_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_ptr_d = w_src_next;
                dst_ptr_d = w_dst_next;
                cnt_d     = cnt_q - C_CNT_ONE;
                if (cnt_q != C_CNT_ONE) begin
                    ad_d    = w_src_next;
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ad   = ad_q;
    assign bus.st   = st_q;
    assign bus.X    = data_q;
    assign bus.busy = (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_block_copy.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_block_copy
// Description : Scoreboard bench for ram_block_copy with a behavioural RAM.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ram_block_copy;

    localparam int BW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_block_copy_if #(.BUS_WIDTH(BW), .ADDRESS_WIDTH(AW)) bus ();

    ram_block_copy #(.BUS_WIDTH(BW), .ADDRESS_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [BW-1:0] mem [DEPTH];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_a  = '0;
    logic [BW-1:0] pl_d  = '0;

    assign bus.O = mem[bus.ad];

    always @(posedge clk) begin
        if (pl_we)       mem[pl_a]   <= pl_d;
        else if (bus.st) mem[bus.ad] <= bus.X;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t wq[$];
    int  dq[$];
    int  ref_mem[DEPTH];
    int  busy_lo = -1;
    int  busy_hi = -2;
    int  n_tests = 0;
    int  n_fail  = 0;

    // Monitor: every store and every done pulse must match the next expectation
    always @(negedge clk) begin
        logic exp_b;
        wr_t  e;
        int   dc;
        if (rst_n) begin
            exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
            n_tests++;
            if (bus.busy !== exp_b) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, exp_b);
            end
            if (bus.st !== 1'b0) begin
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_store cyc=%0d ad=%0d X=%0d", cyc, bus.ad, bus.X);
                end else begin
                    e = wq.pop_front();
                    if (bus.st !== 1'b1 || cyc != e.cyc || int'(bus.ad) != e.addr || int'(bus.X) != e.data) begin
                        n_fail++;
                        $display("FAIL store got cyc=%0d ad=%0d X=%0d want cyc=%0d ad=%0d X=%0d",
                                 cyc, bus.ad, bus.X, e.cyc, e.addr, e.data);
                    end
                end
            end
            if (bus.done !== 1'b0) begin
                n_tests++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done cyc=%0d", cyc);
                end else begin
                    dc = dq.pop_front();
                    if (bus.done !== 1'b1 || cyc != dc) begin
                        n_fail++;
                        $display("FAIL done_timing got cyc=%0d want cyc=%0d", cyc, dc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic check_end();
        chk("pending_stores", wq.size(), 0);
        chk("pending_done", dq.size(), 0);
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("mem[%0d]", a), {24'd0, mem[a]}, ref_mem[a]);
    endtask

    task automatic preload(input int v0, input int v1, input int v2, input int v3);
        int v[DEPTH];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < DEPTH; i++) begin
            pl_we = 1'b1;
            pl_a  = AW'(i);
            pl_d  = BW'(v[i]);
            ref_mem[i] = v[i] & 8'hFF;
            @(negedge clk);
        end
        pl_we = 1'b0;
    endtask

    // Reference: plain forward word-by-word copy; cycle k after accept is cyc a+k-1
    task automatic do_copy(input int s, input int d, input int l);
        int  a;
        int  dn;
        wr_t e;
        a  = cyc + 1;
        dn = a + 2 * l;
        for (int i = 0; i < l; i++) begin
            ref_mem[(d + i) % DEPTH] = ref_mem[(s + i) % DEPTH];
            e.cyc  = a + 2 * i + 1;
            e.addr = (d + i) % DEPTH;
            e.data = ref_mem[(d + i) % DEPTH];
            wq.push_back(e);
        end
        dq.push_back(dn);
        busy_lo   = a;
        busy_hi   = a + 2 * l - 1;
        bus.start = 1'b1;
        bus.src   = AW'(s);
        bus.dst   = AW'(d);
        bus.len   = (AW + 1)'(l);
        forever begin
            @(negedge clk);
            if (cyc > dn) break;
            bus.start = 1'($urandom_range(0, 1));
            bus.src   = AW'($urandom);
            bus.dst   = AW'($urandom);
            bus.len   = (AW + 1)'($urandom_range(0, DEPTH));
        end
        bus.start = 1'b0;
        check_end();
    endtask

    task automatic reset_mid_copy(input int s, input int d);
        int  a;
        wr_t e;
        a = cyc + 1;
        ref_mem[d % DEPTH] = ref_mem[s % DEPTH];
        e.cyc  = a + 1;
        e.addr = d % DEPTH;
        e.data = ref_mem[d % DEPTH];
        wq.push_back(e);
        busy_lo   = a;
        busy_hi   = a + 2;
        bus.start = 1'b1;
        bus.src   = AW'(s);
        bus.dst   = AW'(d);
        bus.len   = (AW + 1)'(DEPTH);
        @(negedge clk);
        bus.start = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < a + 3);
        rst_n = 1'b0;
        #1;
        chk("abort_st", bus.st, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_ad", bus.ad, 0);
        chk("abort_X", bus.X, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, l;
        bus.start = 1'b0;
        bus.src   = '0;
        bus.dst   = '0;
        bus.len   = '0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_st", bus.st, 0);
        chk("rst_ad", bus.ad, 0);
        chk("rst_X", bus.X, 0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(10, 20, 30, 40);
        do_copy(0, 2, 2);
        preload(1, 2, 3, 4);
        do_copy(3, 1, 2);
        do_copy(1, 2, 0);
        preload(7, 8, 9, 5);
        do_copy(0, 1, 3);

        preload(11, 22, 33, 44);
        reset_mid_copy(1, 3);
        do_copy(2, 0, 3);
        do_copy(1, 2, DEPTH);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0)
                preload($urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255));
            s = $urandom_range(0, DEPTH - 1);
            d = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, DEPTH);
            do_copy(s, d, l);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
